// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the register-file writeback arbiter
// Contents: wb_req_t (one register-file write request), REG_ZERO, FILE_GPR/FILE_FPR.
package wb_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic       FILE_GPR = 1'b0;
    localparam logic       FILE_FPR = 1'b1;

    typedef struct packed {
        logic        fp;
        logic [4:0]  Rw;
        logic [31:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - bus bundle between pipeline/multi-cycle unit/ID and the writeback arbiter
// master: pipeline, multi-cycle unit and ID side (drives requests, sees write port and stall)
// slave : the arbiter (accepts requests, drives write port, mc_ready and Stall_MC)
interface wb_port_arbiter_if;

    logic        pipe_we;
    logic        pipe_fp;
    logic [4:0]  pipe_Rw;
    logic [31:0] pipe_data;

    logic        mc_valid;
    logic        mc_ready;
    logic        mc_fp;
    logic [4:0]  mc_Rw;
    logic [31:0] mc_data;

    logic        issue_valid;
    logic        issue_fp;
    logic [4:0]  issue_Rw;

    logic        id_src_fp;
    logic [4:0]  Rs_ID;
    logic [4:0]  Rt_ID;

    logic        reg_we_gpr;
    logic        reg_we_fpr;
    logic [4:0]  Rw_out;
    logic [31:0] BUS_W_out;
    logic        Stall_MC;

    modport master (
        output pipe_we, pipe_fp, pipe_Rw, pipe_data,
        output mc_valid, mc_fp, mc_Rw, mc_data,
        input  mc_ready,
        output issue_valid, issue_fp, issue_Rw,
        output id_src_fp, Rs_ID, Rt_ID,
        input  reg_we_gpr, reg_we_fpr, Rw_out, BUS_W_out, Stall_MC
    );

    modport slave (
        input  pipe_we, pipe_fp, pipe_Rw, pipe_data,
        input  mc_valid, mc_fp, mc_Rw, mc_data,
        output mc_ready,
        input  issue_valid, issue_fp, issue_Rw,
        input  id_src_fp, Rs_ID, Rt_ID,
        output reg_we_gpr, reg_we_fpr, Rw_out, BUS_W_out, Stall_MC
    );

endinterface

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - DEPTH-entry synchronous FIFO of wb_req_t for multi-cycle results
// Ports: clk, reset (sync, active-high), push/push_data, pop, head (current entry),
//        full, empty, count (0..DEPTH). Push while full and pop while empty are ignored.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  wb_req_t       push_data,
    input  logic          pop,
    output wb_req_t       head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    wb_req_t         mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - shares the GPR/FPR write port between pipeline writeback and the multi-cycle unit
// Ports: clk, reset (sync, active-high), bus (wb_port_arbiter_if.slave):
//   pipe_*  : pipeline writeback, always accepted, highest priority
//   mc_*    : multi-cycle results with valid/ready, buffered in a DEPTH-entry FIFO
//   issue_* : long-latency issue from ID, marks destination busy
//   id_src_fp, Rs_ID, Rt_ID : ID source operands checked against the busy scoreboard
//   reg_we_gpr, reg_we_fpr, Rw_out, BUS_W_out : registered write port; Stall_MC : ID stall
// Optional: WB_BYPASS_EN lets a multi-cycle result skip the empty FIFO when the port is idle.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input logic              clk,
    input logic              reset,
    wb_port_arbiter_if.slave bus
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    wb_req_t         pipe_req;
    wb_req_t         mc_req;
    wb_req_t         head;
    wb_req_t         sel_req;
    logic            sel_valid;
    logic            sel_mc;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic            fifo_push;
    logic            fifo_pop;
    logic            mc_ready_i;
    logic            mc_accept;
    logic            bypass;

    logic            reg_we_gpr_q;
    logic            reg_we_fpr_q;
    logic [4:0]      Rw_q;
    logic [31:0]     data_q;

    logic [31:0]     busy_gpr;
    logic [31:0]     busy_fpr;
    logic [31:0]     busy_gpr_n;
    logic [31:0]     busy_fpr_n;
    logic            src_busy;

    assign pipe_req = '{fp: bus.pipe_fp, Rw: bus.pipe_Rw, data: bus.pipe_data};
    assign mc_req   = '{fp: bus.mc_fp,   Rw: bus.mc_Rw,   data: bus.mc_data};

    assign mc_ready_i = (fifo_count < DEPTH_C);
    assign mc_accept  = bus.mc_valid & mc_ready_i;

`ifdef WB_BYPASS_EN
    // Idle port and nothing queued: hand the result straight to the output register.
    assign bypass = ~bus.pipe_we & fifo_empty & bus.mc_valid;
`else
    assign bypass = 1'b0;
`endif

    assign fifo_push = mc_accept & ~bypass;
    assign fifo_pop  = ~bus.pipe_we & ~fifo_empty;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (mc_req),
        .pop       (fifo_pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Pipeline first (it cannot stall), then queued results, then bypass.
    always_comb begin
        sel_valid = 1'b0;
        sel_mc    = 1'b0;
        sel_req   = pipe_req;
        if (bus.pipe_we) begin
            sel_valid = 1'b1;
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
            sel_mc    = 1'b1;
            sel_req   = head;
        end else if (bypass) begin
            sel_valid = 1'b1;
            sel_mc    = 1'b1;
            sel_req   = mc_req;
        end
    end

    // GPR R0 writes still pop and clear, but never assert the enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_we_gpr_q <= 1'b0;
            reg_we_fpr_q <= 1'b0;
            Rw_q         <= '0;
            data_q       <= '0;
        end else begin
            reg_we_gpr_q <= sel_valid & (sel_req.fp == FILE_GPR) & (sel_req.Rw != REG_ZERO);
            reg_we_fpr_q <= sel_valid & (sel_req.fp == FILE_FPR);
            if (sel_valid) begin
                Rw_q   <= sel_req.Rw;
                data_q <= sel_req.data;
            end
        end
    end

    // Clear first, then set, so a same-cycle issue to the same register stays busy.
    always_comb begin
        busy_gpr_n = busy_gpr;
        busy_fpr_n = busy_fpr;
        if (sel_valid && sel_mc) begin
            if (sel_req.fp == FILE_FPR) begin
                busy_fpr_n[sel_req.Rw] = 1'b0;
            end else begin
                busy_gpr_n[sel_req.Rw] = 1'b0;
            end
        end
        if (bus.issue_valid) begin
            if (bus.issue_fp == FILE_FPR) begin
                busy_fpr_n[bus.issue_Rw] = 1'b1;
            end else if (bus.issue_Rw != REG_ZERO) begin
                busy_gpr_n[bus.issue_Rw] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_gpr <= '0;
            busy_fpr <= '0;
        end else begin
            busy_gpr <= busy_gpr_n;
            busy_fpr <= busy_fpr_n;
        end
    end

    assign src_busy = (bus.id_src_fp == FILE_FPR)
                    ? (busy_fpr[bus.Rs_ID] | busy_fpr[bus.Rt_ID])
                    : (busy_gpr[bus.Rs_ID] | busy_gpr[bus.Rt_ID]);

    assign bus.Stall_MC   = src_busy | (bus.issue_valid & ~mc_ready_i);
    assign bus.mc_ready   = mc_ready_i;
    assign bus.reg_we_gpr = reg_we_gpr_q;
    assign bus.reg_we_fpr = reg_we_fpr_q;
    assign bus.Rw_out     = Rw_q;
    assign bus.BUS_W_out  = data_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - scoreboard bench for wb_port_arbiter (default DEPTH=2)
module tb_wb_port_arbiter;
    import wb_pkg::*;

`ifdef WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wb_port_arbiter_if bus ();

    wb_port_arbiter #(.DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int      tests = 0;
    int      fails = 0;
    wb_req_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic fp, input logic [4:0] rw, input logic [31:0] d);
        wb_req_t e;
        e.fp   = fp;
        e.Rw   = rw;
        e.data = d;
        exp_q.push_back(e);
    endtask

    initial begin
        logic found;

        reset           = 1'b1;
        bus.pipe_we     = 1'b0;
        bus.pipe_fp     = 1'b0;
        bus.pipe_Rw     = '0;
        bus.pipe_data   = '0;
        bus.mc_valid    = 1'b1;
        bus.mc_fp       = 1'b0;
        bus.mc_Rw       = 5'd1;
        bus.mc_data     = 32'h1;
        bus.issue_valid = 1'b0;
        bus.issue_fp    = 1'b0;
        bus.issue_Rw    = '0;
        bus.id_src_fp   = 1'b0;
        bus.Rs_ID       = '0;
        bus.Rt_ID       = '0;

        // Monitor: every visible write must match the head of the expected queue.
        fork
            forever begin
                @(negedge clk);
                if (bus.reg_we_gpr || bus.reg_we_fpr) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_write: got Rw=%0d data=0x%0h expected no write at %0t",
                                 bus.Rw_out, bus.BUS_W_out, $time);
                    end else begin
                        wb_req_t e;
                        e = exp_q.pop_front();
                        check("wr_fpr_en", {31'd0, bus.reg_we_fpr}, {31'd0, e.fp});
                        check("wr_gpr_en", {31'd0, bus.reg_we_gpr}, {31'd0, ~e.fp});
                        check("wr_Rw", {27'd0, bus.Rw_out}, {27'd0, e.Rw});
                        check("wr_data", bus.BUS_W_out, e.data);
                    end
                end
            end
        join_none

        // Reset held two cycles with mc_valid high.
        repeat (2) begin
            @(negedge clk);
            check("rst_we_gpr", {31'd0, bus.reg_we_gpr}, 32'd0);
            check("rst_we_fpr", {31'd0, bus.reg_we_fpr}, 32'd0);
            check("rst_mc_ready", {31'd0, bus.mc_ready}, 32'd1);
            check("rst_stall", {31'd0, bus.Stall_MC}, 32'd0);
        end
        cyc();
        reset        = 1'b0;
        bus.mc_valid = 1'b0;
        repeat (3) cyc();

        // Single multi-cycle result on an idle port.
        bus.mc_valid = 1'b1;
        bus.mc_fp    = 1'b0;
        bus.mc_Rw    = 5'd7;
        bus.mc_data  = 32'hDEADBEEF;
        expect_wr(1'b0, 5'd7, 32'hDEADBEEF);
        cyc();
        bus.mc_valid = 1'b0;
        @(negedge clk);
        check("lat_first_cycle", {31'd0, bus.reg_we_gpr}, {31'd0, BYP});
        cyc();
        @(negedge clk);
        check("lat_second_cycle", {31'd0, bus.reg_we_gpr}, {31'd0, ~BYP});
        repeat (2) cyc();

        // Pipeline busy for 4 cycles while two results arrive.
        for (int i = 0; i < 4; i++) expect_wr(1'(i), 5'(10 + i), 32'h1000 + i);
        expect_wr(1'b0, 5'd3, 32'h300);
        expect_wr(1'b0, 5'd4, 32'h301);
        for (int i = 0; i < 4; i++) begin
            bus.pipe_we     = 1'b1;
            bus.pipe_fp     = 1'(i);
            bus.pipe_Rw     = 5'(10 + i);
            bus.pipe_data   = 32'h1000 + i;
            bus.mc_valid    = (i < 2);
            bus.mc_fp       = 1'b0;
            bus.mc_Rw       = 5'(3 + i);
            bus.mc_data     = 32'h300 + i;
            bus.issue_valid = (i == 3);
            bus.issue_fp    = 1'b0;
            bus.issue_Rw    = 5'd0;
            @(negedge clk);
            check("burst_mc_ready", {31'd0, bus.mc_ready}, (i < 2) ? 32'd1 : 32'd0);
            if (i == 3) check("full_issue_stall", {31'd0, bus.Stall_MC}, 32'd1);
            cyc();
        end
        bus.pipe_we     = 1'b0;
        bus.mc_valid    = 1'b0;
        bus.issue_valid = 1'b0;
        @(negedge clk);
        check("full_held", {31'd0, bus.mc_ready}, 32'd0);
        repeat (4) cyc();
        @(negedge clk);
        check("drained_ready", {31'd0, bus.mc_ready}, 32'd1);

        // RAW on GPR 5 until its result is written.
        cyc();
        bus.issue_valid = 1'b1;
        bus.issue_fp    = 1'b0;
        bus.issue_Rw    = 5'd5;
        @(negedge clk);
        check("issue_cycle_stall", {31'd0, bus.Stall_MC}, 32'd0);
        cyc();
        bus.issue_valid = 1'b0;
        bus.Rs_ID       = 5'd5;
        @(negedge clk);
        check("raw_stall", {31'd0, bus.Stall_MC}, 32'd1);
        cyc();
        bus.mc_valid = 1'b1;
        bus.mc_fp    = 1'b0;
        bus.mc_Rw    = 5'd5;
        bus.mc_data  = 32'h55;
        expect_wr(1'b0, 5'd5, 32'h55);
        cyc();
        bus.mc_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 6 && !found; k++) begin
            @(negedge clk);
            if (bus.reg_we_gpr && bus.Rw_out == 5'd5) begin
                check("raw_released", {31'd0, bus.Stall_MC}, 32'd0);
                found = 1'b1;
            end else begin
                check("raw_held", {31'd0, bus.Stall_MC}, 32'd1);
            end
            cyc();
        end
        if (!found) begin
            tests++;
            fails++;
            $display("FAIL raw_write_timeout: got no Rw=5 write expected one within 6 cycles");
        end
        bus.Rs_ID = 5'd0;
        bus.Rt_ID = 5'd5;
        @(negedge clk);
        check("rt_clear", {31'd0, bus.Stall_MC}, 32'd0);
        cyc();
        bus.Rt_ID       = 5'd0;
        bus.issue_valid = 1'b1;
        bus.issue_Rw    = 5'd0;
        cyc();
        bus.issue_valid = 1'b0;
        @(negedge clk);
        check("r0_no_stall", {31'd0, bus.Stall_MC}, 32'd0);

        // FPR 9: issue coincides with its own result reaching the output register.
        cyc();
        bus.issue_valid = 1'b1;
        bus.issue_fp    = 1'b1;
        bus.issue_Rw    = 5'd9;
        cyc();
        bus.mc_valid    = 1'b1;
        bus.mc_fp       = 1'b1;
        bus.mc_Rw       = 5'd9;
        bus.mc_data     = 32'h99;
        expect_wr(1'b1, 5'd9, 32'h99);
        bus.issue_valid = BYP;
        cyc();
        bus.mc_valid    = 1'b0;
        bus.issue_valid = ~BYP;
        cyc();
        bus.issue_valid = 1'b0;
        bus.Rs_ID       = 5'd9;
        bus.id_src_fp   = 1'b1;
        @(negedge clk);
        check("fpr9_set_wins", {31'd0, bus.Stall_MC}, 32'd1);
        cyc();
        bus.id_src_fp = 1'b0;
        @(negedge clk);
        check("fpr9_gpr_src", {31'd0, bus.Stall_MC}, 32'd0);
        cyc();
        bus.mc_valid = 1'b1;
        bus.mc_data  = 32'h9A;
        expect_wr(1'b1, 5'd9, 32'h9A);
        cyc();
        bus.mc_valid = 1'b0;
        repeat (3) cyc();
        bus.id_src_fp = 1'b1;
        @(negedge clk);
        check("fpr9_cleared", {31'd0, bus.Stall_MC}, 32'd0);
        cyc();
        bus.id_src_fp = 1'b0;
        bus.Rs_ID     = 5'd0;

        // GPR R0 result is suppressed but still leaves the FIFO.
        bus.mc_valid = 1'b1;
        bus.mc_fp    = 1'b0;
        bus.mc_Rw    = 5'd0;
        bus.mc_data  = 32'hBAD;
        cyc();
        bus.mc_Rw    = 5'd6;
        bus.mc_data  = 32'h66;
        expect_wr(1'b0, 5'd6, 32'h66);
        cyc();
        bus.mc_valid = 1'b0;
        repeat (4) cyc();
        @(negedge clk);
        check("r0_popped_ready", {31'd0, bus.mc_ready}, 32'd1);

        // Mid-operation reset discards queued results and busy bits.
        cyc();
        bus.pipe_we     = 1'b1;
        bus.pipe_fp     = 1'b0;
        bus.pipe_Rw     = 5'd17;
        bus.pipe_data   = 32'h1700;
        expect_wr(1'b0, 5'd17, 32'h1700);
        bus.mc_valid    = 1'b1;
        bus.mc_Rw       = 5'd20;
        bus.mc_data     = 32'h2000;
        bus.issue_valid = 1'b1;
        bus.issue_fp    = 1'b0;
        bus.issue_Rw    = 5'd12;
        cyc();
        bus.pipe_Rw     = 5'd18;
        bus.pipe_data   = 32'h1800;
        expect_wr(1'b0, 5'd18, 32'h1800);
        bus.mc_Rw       = 5'd21;
        bus.mc_data     = 32'h2100;
        bus.issue_valid = 1'b0;
        cyc();
        bus.pipe_we  = 1'b0;
        bus.mc_valid = 1'b0;
        reset        = 1'b1;
        @(negedge clk);
        check("pre_reset_full", {31'd0, bus.mc_ready}, 32'd0);
        cyc();
        reset     = 1'b0;
        bus.Rs_ID = 5'd12;
        @(negedge clk);
        check("midrst_ready", {31'd0, bus.mc_ready}, 32'd1);
        check("midrst_we", {30'd0, bus.reg_we_gpr, bus.reg_we_fpr}, 32'd0);
        check("midrst_busy", {31'd0, bus.Stall_MC}, 32'd0);
        repeat (4) cyc();
        bus.Rs_ID = 5'd0;

        check("exp_queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
